// File: rtl/argmax_pkg.sv
// Shared types and constants for the output argmax decision stage.
package argmax_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DW_DEF     = 16;
   localparam int BEAT_CNT_W = 16;
endpackage

// File: rtl/layer_argmax_if.sv
// Score-vector in / class-result out handshake bundle for layer_argmax.
interface layer_argmax_if
   import argmax_pkg::*;
#(
   parameter int NUM_IN = 5,
   parameter int DW     = DW_DEF,
   parameter int IDXW   = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [NUM_IN*DW-1:0]  in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [IDXW-1:0]       out_class;
   logic [DW-1:0]         out_max;
   logic                  out_tie;
   logic [BEAT_CNT_W-1:0] beat_cnt;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_class, out_max, out_tie, beat_cnt
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_class, out_max, out_tie, beat_cnt
   );
endinterface

// File: rtl/argmax_cmp.sv
// Signed magnitude comparator: gt = a > b, eq = a == b. Purely combinational.
module argmax_cmp #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic          o_gt,
   output logic          o_eq
);
   assign o_gt = $signed(i_a) > $signed(i_b);
   assign o_eq = (i_a == i_b);
endmodule

// File: rtl/layer_argmax.sv
// Captures a score vector, scans it one entry per cycle, reports index/value of the max.
// Result appears NUM_IN-1 cycles after capture; held in DONE until out_ready, in_ready only in IDLE.
module layer_argmax
   import argmax_pkg::*;
#(
   parameter int NUM_IN = 5,
   parameter int DW     = DW_DEF,
   parameter int IDXW   = 4
) (
   input  logic           clk,
   input  logic           reset,
   layer_argmax_if.slave  io
);
   localparam int BW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DW-1:0]         r_buf [NUM_IN];
   logic [IDXW-1:0]       r_idx;
   logic [DW-1:0]         r_best_val;
   logic [IDXW-1:0]       r_best_idx;
   logic                  r_tie;
   logic [BEAT_CNT_W-1:0] r_beat_cnt;

   logic                  w_capture;
   logic                  w_accept;
   logic                  w_last;
   logic [DW-1:0]         w_cur;
   logic                  w_gt;
   logic                  w_eq;

   assign w_cur = r_buf[r_idx[BW-1:0]];

   argmax_cmp #(.DW(DW)) u_cmp (
      .i_a  (w_cur),
      .i_b  (r_best_val),
      .o_gt (w_gt),
      .o_eq (w_eq)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_accept    = 1'b0;
      w_last      = (r_idx == IDXW'(NUM_IN - 1));
      case (r_state)
         IDLE: if (io.in_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = SCAN;
         end
         SCAN: if (w_last) w_state_nxt = DONE;
         DONE: if (io.out_ready) begin
            w_accept    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_IN; k++) r_buf[k] <= '0;
         r_idx      <= '0;
         r_best_val <= '0;
         r_best_idx <= '0;
         r_tie      <= 1'b0;
         r_beat_cnt <= '0;
      end else begin
         if (w_capture) begin
            for (int k = 0; k < NUM_IN; k++) r_buf[k] <= io.in_data[k*DW +: DW];
            r_best_val <= io.in_data[DW-1:0];
            r_best_idx <= '0;
            r_tie      <= 1'b0;
            r_idx      <= IDXW'(1);
         end
         if (r_state == SCAN) begin
            // Equal scores keep the earlier index so the lowest class wins ties.
            if (w_gt) begin
               r_best_val <= w_cur;
               r_best_idx <= r_idx;
               r_tie      <= 1'b0;
            end else if (w_eq) begin
               r_tie      <= 1'b1;
            end
            r_idx <= r_idx + IDXW'(1);
         end
         if (w_accept && (r_beat_cnt != {BEAT_CNT_W{1'b1}}))
            r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
      end
   end

   assign io.in_ready  = (r_state == IDLE);
   assign io.out_valid = (r_state == DONE);
   assign io.out_class = r_best_idx;
   assign io.out_max   = r_best_val;
   assign io.out_tie   = r_tie;
   assign io.beat_cnt  = r_beat_cnt;
endmodule

// File: tb/tb_layer_argmax.sv
// Randomized and directed checks of layer_argmax against a max/first-index reference model.
module tb_layer_argmax;
   localparam int NUM_IN = 5;
   localparam int DW     = 16;
   localparam int IDXW   = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [15:0] mdl_cnt;
   logic [15:0] vec [NUM_IN];

   always #5 clk = ~clk;

   layer_argmax_if #(.NUM_IN(NUM_IN), .DW(DW), .IDXW(IDXW)) u_if ();

   layer_argmax #(.NUM_IN(NUM_IN), .DW(DW), .IDXW(IDXW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .io    (u_if.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: find the maximum signed value, then the first index holding it.
   function automatic void ref_argmax(input logic [15:0] v [NUM_IN], output int cls,
                                      output logic [15:0] mx, output bit tie);
      int best;
      int hits;
      best = $signed(v[0]);
      for (int k = 1; k < NUM_IN; k++)
         if ($signed(v[k]) > best) best = $signed(v[k]);
      hits = 0;
      cls  = -1;
      for (int k = 0; k < NUM_IN; k++)
         if ($signed(v[k]) == best) begin
            hits++;
            if (cls < 0) cls = k;
         end
      mx  = best[15:0];
      tie = (hits > 1);
   endfunction

   task automatic start_vec(input bit early_rdy, input string tag);
      chk({tag, "_in_ready"}, 32'(u_if.in_ready), 32'd1);
      u_if.in_valid  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) u_if.in_data[k*DW +: DW] = vec[k];
      u_if.out_ready = early_rdy;
      @(posedge clk);
      @(negedge clk);
      u_if.in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int cls;
      logic [15:0] mx;
      bit tie;
      int lat;
      ref_argmax(vec, cls, mx, tie);
      lat = 0;
      while (!u_if.out_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, 32'(lat), 32'(NUM_IN - 1));
      chk({tag, "_class"}, 32'(u_if.out_class), 32'(cls));
      chk({tag, "_max"}, 32'(u_if.out_max), 32'(mx));
      chk({tag, "_tie"}, 32'(u_if.out_tie), 32'(tie));
   endtask

   task automatic accept(input string tag);
      u_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      u_if.out_ready = 1'b0;
      if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
      chk({tag, "_valid_drop"}, 32'(u_if.out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(u_if.in_ready), 32'd1);
      chk({tag, "_beat_cnt"}, 32'(u_if.beat_cnt), 32'(mdl_cnt));
   endtask

   task automatic run_vec(input bit early_rdy, input string tag);
      start_vec(early_rdy, tag);
      wait_result(tag);
      accept(tag);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, 32'(u_if.in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(u_if.out_valid), 32'd0);
      chk({tag, "_class"}, 32'(u_if.out_class), 32'd0);
      chk({tag, "_max"}, 32'(u_if.out_max), 32'd0);
      chk({tag, "_tie"}, 32'(u_if.out_tie), 32'd0);
      chk({tag, "_beat_cnt"}, 32'(u_if.beat_cnt), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  h_class;
      logic [15:0] h_max;
      logic        h_tie;

      reset          = 1'b1;
      u_if.in_valid  = 1'b0;
      u_if.in_data   = '0;
      u_if.out_ready = 1'b0;
      mdl_cnt        = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_reset_state("rst");

      vec = '{16'd10, 16'd40, 16'd7, 16'd3, 16'd0};
      run_vec(1'b0, "basic");
      vec = '{16'd25, 16'd9, 16'd25, 16'd25, 16'd1};
      run_vec(1'b0, "tie25");
      vec = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
      run_vec(1'b0, "zeros");
      vec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'h7FFF};
      run_vec(1'b0, "last_idx");
      vec = '{16'hFFF0, 16'hFFFB, 16'hFFF8, 16'hFFF4, 16'hFFEC};
      run_vec(1'b0, "signed");

      vec = '{16'd5, 16'd6, 16'd90, 16'd6, 16'd2};
      run_vec(1'b1, "early_rdy");

      // Stall in DONE while new vectors are offered; nothing may move.
      vec = '{16'd7, 16'd300, 16'd12, 16'd300, 16'd8};
      start_vec(1'b0, "hold");
      wait_result("hold");
      h_class = u_if.out_class;
      h_max   = u_if.out_max;
      h_tie   = u_if.out_tie;
      for (int c = 0; c < 10; c++) begin
         u_if.in_valid = 1'($urandom_range(0, 1));
         for (int k = 0; k < NUM_IN; k++) u_if.in_data[k*DW +: DW] = 16'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", 32'(u_if.out_valid), 32'd1);
         chk("hold_in_ready", 32'(u_if.in_ready), 32'd0);
         chk("hold_class", 32'(u_if.out_class), 32'd1);
         chk("hold_max", 32'(u_if.out_max), 32'd300);
         chk("hold_tie", 32'({h_class, h_max, h_tie} == {u_if.out_class, u_if.out_max, u_if.out_tie}), 32'd1);
         chk("hold_beat_cnt", 32'(u_if.beat_cnt), 32'(mdl_cnt));
      end
      u_if.in_valid = 1'b0;
      accept("hold");
      @(posedge clk);
      @(negedge clk);
      chk("hold_no_capture", 32'(u_if.in_ready), 32'd1);

      // Reset during the second SCAN cycle discards the partial result.
      vec = '{16'd100, 16'd200, 16'd50, 16'd100, 16'd1};
      start_vec(1'b0, "midscan");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset   = 1'b0;
      mdl_cnt = 16'd0;
      chk_reset_state("midscan_rst");
      vec = '{16'd3, 16'd1, 16'd2, 16'd0, 16'd0};
      run_vec(1'b0, "post_rst");

      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < NUM_IN; k++)
            vec[k] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
         run_vec(r % 3 == 0, $sformatf("rand%0d", r));
      end

      // Preload the counter just below saturation.
      force u_dut.r_beat_cnt = 16'hFFFE;
      @(posedge clk);
      @(negedge clk);
      release u_dut.r_beat_cnt;
      mdl_cnt = 16'hFFFE;
      chk("sat_preload", 32'(u_if.beat_cnt), 32'h0000_FFFE);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NUM_IN; k++) vec[k] = 16'($urandom_range(0, 1000));
         run_vec(1'b0, $sformatf("sat%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
